// File: rtl/serdesphy_prbs_chk.sv
// PRBS7 (x^7+x^6+1) receive checker: self-seeds from the incoming stream,
// qualifies lock over a run of matches, then counts errors and drops lock on error bursts.
module serdesphy_prbs_chk #(
  parameter int LOCK_MATCHES = 16,
  parameter int LOSS_ERRS    = 4,
  parameter int WINDOW       = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       rx_bit,
  input  logic       rx_bit_valid,
  input  logic       clear,
  output logic       prbs_lock,
  output logic       prbs_err,
  output logic [7:0] err_count
);

  localparam int MW = $clog2(LOCK_MATCHES + 1);
  localparam int WW = $clog2(WINDOW + 1);
  localparam int EW = $clog2(LOSS_ERRS + 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_MATCHES - 1);
  localparam logic [WW-1:0] WIN_LAST   = WW'(WINDOW - 1);
  localparam logic [EW-1:0] ERR_LAST   = EW'(LOSS_ERRS - 1);

  typedef enum logic [1:0] {IDLE, SEED, VERIFY, LOCKED} state_t;

  state_t          state, state_nxt;
  logic [6:0]      sr, sr_nxt;
  logic [2:0]      seed_cnt, seed_cnt_nxt;
  logic [MW-1:0]   match_cnt, match_nxt;
  logic [WW-1:0]   win_cnt, win_nxt;
  logic [EW-1:0]   win_err, werr_nxt;
  logic            lock_nxt, err_nxt;
  logic [7:0]      count_nxt;
  logic            pred;

  assign pred = sr[6] ^ sr[5];

  always_comb begin
    state_nxt    = state;
    sr_nxt       = sr;
    seed_cnt_nxt = seed_cnt;
    match_nxt    = match_cnt;
    win_nxt      = win_cnt;
    werr_nxt     = win_err;
    lock_nxt     = prbs_lock;
    err_nxt      = 1'b0;
    count_nxt    = err_count;
    if (!en) begin
      state_nxt    = IDLE;
      sr_nxt       = '0;
      seed_cnt_nxt = '0;
      match_nxt    = '0;
      win_nxt      = '0;
      werr_nxt     = '0;
      lock_nxt     = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state_nxt    = SEED;
          seed_cnt_nxt = '0;
        end
        SEED: if (rx_bit_valid) begin
          sr_nxt = {sr[5:0], rx_bit};
          if (seed_cnt == 3'd6) begin
            seed_cnt_nxt = '0;
            state_nxt    = VERIFY;
          end else begin
            seed_cnt_nxt = seed_cnt + 3'd1;
          end
        end
        VERIFY: if (rx_bit_valid) begin
          sr_nxt = {sr[5:0], rx_bit};
          if (rx_bit != pred || sr == '0) begin
            match_nxt    = '0;
            seed_cnt_nxt = '0;
            state_nxt    = SEED;
          end else if (match_cnt == MATCH_LAST) begin
            match_nxt = '0;
            win_nxt   = '0;
            werr_nxt  = '0;
            lock_nxt  = 1'b1;
            state_nxt = LOCKED;
          end else begin
            match_nxt = match_cnt + MW'(1);
          end
        end
        LOCKED: if (rx_bit_valid) begin
          // Generator free-runs on its own prediction so line errors never reach sr.
          sr_nxt  = {sr[5:0], pred};
          err_nxt = (rx_bit != pred);
          if (err_nxt && err_count != 8'hFF) count_nxt = err_count + 8'd1;
          if (err_nxt && win_err == ERR_LAST) begin
            state_nxt    = SEED;
            lock_nxt     = 1'b0;
            seed_cnt_nxt = '0;
            win_nxt      = '0;
            werr_nxt     = '0;
          end else if (win_cnt == WIN_LAST) begin
            win_nxt  = '0;
            werr_nxt = '0;
          end else begin
            win_nxt = win_cnt + WW'(1);
            if (err_nxt) werr_nxt = win_err + EW'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
    if (clear) count_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sr        <= '0;
      seed_cnt  <= '0;
      match_cnt <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      prbs_lock <= 1'b0;
      prbs_err  <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_nxt;
      sr        <= sr_nxt;
      seed_cnt  <= seed_cnt_nxt;
      match_cnt <= match_nxt;
      win_cnt   <= win_nxt;
      win_err   <= werr_nxt;
      prbs_lock <= lock_nxt;
      prbs_err  <= err_nxt;
      err_count <= count_nxt;
    end
  end

endmodule
